// File: rtl/raster_pkg.sv
// Shared raster types: fixed-point coordinates and per-tile metadata.
// Used by the binner and the per-tile rasterizer.
package raster_pkg;

  localparam int FX_INT_BITS = 12;
  localparam int FX_FRAC_BITS = 4;
  localparam int FX_W = FX_INT_BITS + FX_FRAC_BITS;
  localparam int TILE_WIDTH = 16;
  localparam int NUM_VERTICES = 3;
  localparam int TX_W = 6;
  localparam int TY_W = 5;

  typedef logic signed [FX_W-1:0] fx_t;

  typedef struct packed {
    fx_t x;
    fx_t y;
    fx_t z;
  } coord_3d_t;

  typedef struct packed {
    fx_t x;
    fx_t y;
  } coord_2d_t;

  // 40 columns need a 6-bit tile_x, so padding is a single bit
  typedef struct packed {
    logic [3:0]      color;
    logic            padding;
    logic [TY_W-1:0] tile_y;
    logic [TX_W-1:0] tile_x;
  } metadata_t;

  function automatic logic signed [7:0] tile_of(
    input fx_t c,
    input int  sh
  );
    return 8'(c >>> sh);
  endfunction

endpackage

// File: rtl/tile_bbox.sv
// Combinational tile bounding box: shift, min/max, clamp and
// off-screen cull flag for one triangle.
module tile_bbox
  import raster_pkg::*;
#(
  parameter int TILE_COLUMNS = 40,
  parameter int TILE_ROWS    = 30,
  parameter int TILE_SHIFT   = FX_FRAC_BITS + $clog2(TILE_WIDTH)
) (
  input  coord_2d_t       v [NUM_VERTICES],
  output logic [TX_W-1:0] min_x,
  output logic [TX_W-1:0] max_x,
  output logic [TY_W-1:0] min_y,
  output logic [TY_W-1:0] max_y,
  output logic            cull
);

  localparam logic signed [7:0] X_LAST = 8'(TILE_COLUMNS - 1);
  localparam logic signed [7:0] Y_LAST = 8'(TILE_ROWS - 1);

  logic signed [7:0] tx, ty;
  logic signed [7:0] lo_x, hi_x, lo_y, hi_y;
  logic signed [7:0] cx_lo, cx_hi, cy_lo, cy_hi;

  always_comb begin
    lo_x = tile_of(v[0].x, TILE_SHIFT);
    lo_y = tile_of(v[0].y, TILE_SHIFT);
    hi_x = lo_x;
    hi_y = lo_y;
    tx = lo_x;
    ty = lo_y;
    for (int i = 1; i < NUM_VERTICES; i++) begin
      tx = tile_of(v[i].x, TILE_SHIFT);
      ty = tile_of(v[i].y, TILE_SHIFT);
      if (tx < lo_x) lo_x = tx;
      if (tx > hi_x) hi_x = tx;
      if (ty < lo_y) lo_y = ty;
      if (ty > hi_y) hi_y = ty;
    end
  end

  always_comb begin
    cull = (hi_x < 0) || (hi_y < 0) ||
           (lo_x > X_LAST) || (lo_y > Y_LAST);
    cx_lo = (lo_x < 0) ? 8'sd0 : lo_x;
    cy_lo = (lo_y < 0) ? 8'sd0 : lo_y;
    cx_hi = (hi_x > X_LAST) ? X_LAST : hi_x;
    cy_hi = (hi_y > Y_LAST) ? Y_LAST : hi_y;
    min_x = TX_W'(cx_lo);
    max_x = TX_W'(cx_hi);
    min_y = TY_W'(cy_lo);
    max_y = TY_W'(cy_hi);
  end

endmodule

// File: rtl/tile_binner.sv
// Splits one triangle into per-tile rasterizer transactions.
// Define BACKFACE_CULL_EN to drop triangles with area <= 0.
module tile_binner
  import raster_pkg::*;
#(
  parameter int TILE_COLUMNS = 40,
  parameter int TILE_ROWS    = 30,
  parameter int TILE_SHIFT   = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      tri_vld,
  output logic      tri_rdy,
  input  coord_3d_t tri_v0,
  input  coord_3d_t tri_v1,
  input  coord_3d_t tri_v2,
  input  logic [3:0] tri_color,
  output logic      vld_out,
  input  logic      rdy_in,
  output coord_3d_t v0_out,
  output coord_3d_t v1_out,
  output coord_3d_t v2_out,
  output metadata_t metadata_out,
  output logic      busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] EMIT  = 2'd2;

  logic [1:0] state;
  coord_3d_t  v0_q, v1_q, v2_q;
  logic [3:0] color_q;

  logic [TX_W-1:0] cur_x, min_x, max_x;
  logic [TY_W-1:0] cur_y, max_y;

  coord_2d_t       bb_v [NUM_VERTICES];
  logic [TX_W-1:0] bb_min_x, bb_max_x;
  logic [TY_W-1:0] bb_min_y, bb_max_y;
  logic            bb_cull;
  logic            cull;
  logic            last;

  assign bb_v[0] = '{x: v0_q.x, y: v0_q.y};
  assign bb_v[1] = '{x: v1_q.x, y: v1_q.y};
  assign bb_v[2] = '{x: v2_q.x, y: v2_q.y};

  tile_bbox #(
    .TILE_COLUMNS (TILE_COLUMNS),
    .TILE_ROWS    (TILE_ROWS),
    .TILE_SHIFT   (TILE_SHIFT)
  ) u_bbox (
    .v     (bb_v),
    .min_x (bb_min_x),
    .max_x (bb_max_x),
    .min_y (bb_min_y),
    .max_y (bb_max_y),
    .cull  (bb_cull)
  );

`ifdef BACKFACE_CULL_EN
  logic signed [16:0] dx1, dy1, dx2, dy2;
  logic signed [32:0] p1, p2;
  logic signed [33:0] area;

  assign dx1  = v1_q.x - v0_q.x;
  assign dy1  = v1_q.y - v0_q.y;
  assign dx2  = v2_q.x - v0_q.x;
  assign dy2  = v2_q.y - v0_q.y;
  assign p1   = dx1 * dy2;
  assign p2   = dx2 * dy1;
  assign area = p1 - p2;
  assign cull = bb_cull || (area <= 0);
`else
  assign cull = bb_cull;
`endif

  assign last = (cur_x == max_x) && (cur_y == max_y);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      v0_q    <= '0;
      v1_q    <= '0;
      v2_q    <= '0;
      color_q <= '0;
      cur_x   <= '0;
      cur_y   <= '0;
      min_x   <= '0;
      max_x   <= '0;
      max_y   <= '0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (tri_vld) begin
            v0_q    <= tri_v0;
            v1_q    <= tri_v1;
            v2_q    <= tri_v2;
            color_q <= tri_color;
            state   <= SETUP;
          end
        end
        (state == SETUP): begin
          if (cull) begin
            state <= IDLE;
          end else begin
            cur_x <= bb_min_x;
            cur_y <= bb_min_y;
            min_x <= bb_min_x;
            max_x <= bb_max_x;
            max_y <= bb_max_y;
            state <= EMIT;
          end
        end
        (state == EMIT): begin
          if (rdy_in) begin
            if (last) begin
              state <= IDLE;
            end else if (cur_x == max_x) begin
              cur_x <= min_x;
              cur_y <= cur_y + 1'b1;
            end else begin
              cur_x <= cur_x + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign tri_rdy = (state == IDLE);
  assign busy    = (state != IDLE);
  assign vld_out = (state == EMIT);
  assign v0_out  = v0_q;
  assign v1_out  = v1_q;
  assign v2_out  = v2_q;

  assign metadata_out = '{
    color:   color_q,
    padding: 1'b0,
    tile_y:  cur_y,
    tile_x:  cur_x
  };

endmodule

// File: tb/tb_tile_binner.sv
// Directed vector bench for tile_binner: tile order, clamp, cull,
// backpressure and asynchronous reset during emission.
module tb_tile_binner;
  import raster_pkg::*;

`ifdef BACKFACE_CULL_EN
  localparam bit BF_EN = 1'b1;
`else
  localparam bit BF_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       tri_vld;
  logic       tri_rdy;
  coord_3d_t  tri_v0, tri_v1, tri_v2;
  logic [3:0] tri_color;
  logic       vld_out;
  logic       rdy_in;
  coord_3d_t  v0_out, v1_out, v2_out;
  metadata_t  metadata_out;
  logic       busy;

  int checks = 0;
  int errors = 0;

  tile_binner dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tri_vld      (tri_vld),
    .tri_rdy      (tri_rdy),
    .tri_v0       (tri_v0),
    .tri_v1       (tri_v1),
    .tri_v2       (tri_v2),
    .tri_color    (tri_color),
    .vld_out      (vld_out),
    .rdy_in       (rdy_in),
    .v0_out       (v0_out),
    .v1_out       (v1_out),
    .v2_out       (v2_out),
    .metadata_out (metadata_out),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    coord_3d_t  v0, v1, v2;
    logic [3:0] color;
    bit         off;
    bit         bf;
    int         x0, x1, y0, y1;
  } vec_t;

  vec_t tab [10];

  function automatic coord_3d_t c3(logic [15:0] x, logic [15:0] y);
    coord_3d_t c;
    c.x = x;
    c.y = y;
    c.z = 16'h0123;
    return c;
  endfunction

  function automatic vec_t mk(
    logic [15:0] ax, logic [15:0] ay,
    logic [15:0] bx, logic [15:0] by,
    logic [15:0] cx, logic [15:0] cy,
    logic [3:0] col, bit off, bit bf,
    int x0, int x1, int y0, int y1
  );
    vec_t t;
    t.v0 = c3(ax, ay);
    t.v1 = c3(bx, by);
    t.v2 = c3(cx, cy);
    t.color = col;
    t.off = off;
    t.bf = bf;
    t.x0 = x0;
    t.x1 = x1;
    t.y0 = y0;
    t.y1 = y1;
    return t;
  endfunction

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, exp);
    end
  endtask

  function automatic metadata_t md(logic [3:0] col, int x, int y);
    metadata_t m;
    m.color = col;
    m.padding = 1'b0;
    m.tile_y = TY_W'(y);
    m.tile_x = TX_W'(x);
    return m;
  endfunction

  task automatic send(vec_t t);
    int w;
    w = 0;
    while (!tri_rdy && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (!tri_rdy) chk("tri_rdy_timeout", 64'(tri_rdy), 64'd1);
    tri_vld   = 1'b1;
    tri_v0    = t.v0;
    tri_v1    = t.v1;
    tri_v2    = t.v2;
    tri_color = t.color;
    @(posedge clk);
    #1;
    tri_vld = 1'b0;
    tri_v0  = '0;
    tri_v1  = '0;
    tri_v2  = '0;
  endtask

  task automatic run_tri(vec_t t, bit toggle, string nm);
    metadata_t exp_q [$];
    metadata_t prev_m;
    coord_3d_t prev_v;
    bit        pat [4];
    bit        cull;
    bit        hold;
    int        got;
    int        k;
    pat[0] = 1'b1;
    pat[1] = 1'b0;
    pat[2] = 1'b0;
    pat[3] = 1'b1;
    cull = t.off || (BF_EN && t.bf);
    if (!cull)
      for (int y = t.y0; y <= t.y1; y++)
        for (int x = t.x0; x <= t.x1; x++)
          exp_q.push_back(md(t.color, x, y));
    rdy_in = 1'b1;
    send(t);
    chk({nm, "_setup_vld"}, 64'(vld_out), 64'd0);
    chk({nm, "_setup_rdy"}, 64'(tri_rdy), 64'd0);
    chk({nm, "_setup_busy"}, 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    if (cull) begin
      chk({nm, "_cull_rdy"}, 64'(tri_rdy), 64'd1);
      chk({nm, "_cull_vld"}, 64'(vld_out), 64'd0);
    end else begin
      chk({nm, "_first_vld"}, 64'(vld_out), 64'd1);
      chk({nm, "_v0"}, 64'(v0_out), 64'(t.v0));
      chk({nm, "_v1"}, 64'(v1_out), 64'(t.v1));
      chk({nm, "_v2"}, 64'(v2_out), 64'(t.v2));
      got = 0;
      k = 0;
      hold = 1'b0;
      prev_m = '0;
      prev_v = '0;
      while (k < 400) begin
        if (hold) begin
          chk({nm, "_hold_vld"}, 64'(vld_out), 64'd1);
          chk({nm, "_hold_md"}, 64'(metadata_out), 64'(prev_m));
          chk({nm, "_hold_v0"}, 64'(v0_out), 64'(prev_v));
        end
        if (!vld_out) break;
        rdy_in = toggle ? pat[k % 4] : 1'b1;
        if (rdy_in) begin
          if (got < exp_q.size())
            chk({nm, "_tile"}, 64'(metadata_out), 64'(exp_q[got]));
          else
            chk({nm, "_extra_tile"}, 64'(metadata_out), 64'd0);
          got++;
        end
        hold = !rdy_in;
        prev_m = metadata_out;
        prev_v = v0_out;
        k++;
        @(posedge clk);
        #1;
      end
      rdy_in = 1'b0;
      if (k >= 400) chk({nm, "_timeout"}, 64'(k), 64'd0);
      chk({nm, "_count"}, 64'(got), 64'(exp_q.size()));
      chk({nm, "_end_rdy"}, 64'(tri_rdy), 64'd1);
      chk({nm, "_end_busy"}, 64'(busy), 64'd0);
    end
  endtask

  initial begin
    tab[0] = mk(16'h0140, 16'h0150, 16'h01F0, 16'h0150,
                16'h0140, 16'h01E0, 4'd5, 0, 0, 1, 1, 1, 1);
    tab[1] = mk(16'h0000, 16'h0000, 16'h02FF, 16'h0000,
                16'h0000, 16'h01FF, 4'd3, 0, 0, 0, 2, 0, 1);
    tab[2] = mk(16'hF000, 16'h0000, 16'hF000, 16'h0100,
                16'hF000, 16'h0200, 4'd7, 1, 0, 0, 0, 0, 0);
    tab[3] = mk(16'hFF00, 16'h0000, 16'h2900, 16'h0000,
                16'h0000, 16'h0000, 4'd9, 0, 1, 0, 39, 0, 0);
    tab[4] = mk(16'h2000, 16'h1C00, 16'h2A00, 16'h1C00,
                16'h2000, 16'h2200, 4'd12, 0, 0, 32, 39, 28, 29);
    tab[5] = mk(16'hFE00, 16'hFE00, 16'h0100, 16'hFE00,
                16'hFE00, 16'h0100, 4'd1, 0, 0, 0, 1, 0, 1);
    tab[6] = mk(16'h0000, 16'h1E00, 16'h0100, 16'h1E00,
                16'h0000, 16'h1F00, 4'd2, 1, 0, 0, 0, 0, 0);
    tab[7] = mk(16'h2800, 16'h0000, 16'h2900, 16'h0000,
                16'h2800, 16'h0100, 4'd4, 1, 0, 0, 0, 0, 0);
    tab[8] = mk(16'h0500, 16'h0300, 16'h0500, 16'h0300,
                16'h0500, 16'h0300, 4'd15, 0, 1, 5, 5, 3, 3);
    tab[9] = mk(16'h0000, 16'h0000, 16'h0000, 16'h01FF,
                16'h02FF, 16'h0000, 4'd6, 0, 1, 0, 2, 0, 1);

    rst_n     = 1'b0;
    tri_vld   = 1'b0;
    rdy_in    = 1'b0;
    tri_v0    = '0;
    tri_v1    = '0;
    tri_v2    = '0;
    tri_color = '0;
    #12;
    chk("rst_tri_rdy", 64'(tri_rdy), 64'd1);
    chk("rst_vld", 64'(vld_out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_v0", 64'(v0_out), 64'd0);
    chk("rst_md", 64'(metadata_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++)
      run_tri(tab[i], 1'b0, $sformatf("vec%0d", i));

    run_tri(tab[1], 1'b1, "bp");

    // reset while the third tile is on the output
    rdy_in = 1'b1;
    send(tab[1]);
    @(posedge clk);
    #1;
    chk("rm_tile0", 64'(metadata_out), 64'(md(4'd3, 0, 0)));
    @(posedge clk);
    #1;
    chk("rm_tile1", 64'(metadata_out), 64'(md(4'd3, 1, 0)));
    @(posedge clk);
    #1;
    chk("rm_tile2", 64'(metadata_out), 64'(md(4'd3, 2, 0)));
    chk("rm_vld_pre", 64'(vld_out), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rm_vld", 64'(vld_out), 64'd0);
    chk("rm_tri_rdy", 64'(tri_rdy), 64'd1);
    chk("rm_busy", 64'(busy), 64'd0);
    rdy_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_tri(tab[0], 1'b0, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
